// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised Mealy serial-pattern detector.
// A runtime-loadable PAT_W-bit pattern is compared against the last
// PAT_W-1 accepted bits plus the bit on the input in the current cycle.
// Overlapping and non-overlapping matching are supported, x_valid
// qualifies the input, and pat_load replaces the pattern and flushes the
// history.
// Optional feature macro: SEQDET_COUNT_EN builds a saturating match
// counter on `count`. Without it, `count` is tied to zero and
// `count_clr` is ignored.
module seq_detector_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active low
    input  logic             x,
    input  logic             x_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             count_clr,
    output logic             y,
    output logic [CNT_W-1:0] count
);

    // fill counts accepted history bits, 0..PAT_W-1
    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } fill_state_e;

    fill_state_e       state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // History with the live bit appended; oldest bit lands in the MSB so it
    // lines up with the pattern register directly.
    logic [PAT_W-1:0]  window;
    logic              match;

    assign window = {hist_q, x};

    // Mealy output: only when a full history is present and the input is taken
    assign match = x_valid & ~pat_load & (state_q == ARMED) & (window == pat_q);
    assign y     = match;

    // State register: pattern, history, fill level and its state label
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            pat_q   <= PATTERN;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state logic: pattern load wins over data; a non-overlap match
    // restarts the fill so the next match needs a full PAT_W fresh bits.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (x_valid) begin
            // Drop the oldest bit; for PAT_W=2 this is simply hist <= x
            hist_d = window[PAT_W-2:0];
            if (match && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        if (fill_d == '0) begin
            state_d = EMPTY;
        end else if (fill_d == FILL_MAX) begin
            state_d = ARMED;
        end else begin
            state_d = FILLING;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter; a clear coinciding with a match keeps that match
    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
`else
    // No counter in this build; the clear input has nothing to act on
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign count            = '0;
`endif

endmodule
